// File: rtl/groovy_audio_stream_if.sv
// Memory read port between groovy_audio_stream (master) and the DDR arbiter (slave).
// One request per mem_rd pulse; mem_ack returns the word on mem_data.
interface groovy_audio_stream_if;
    logic        mem_rd;
    logic [23:0] mem_addr;
    logic        mem_busy;
    logic        mem_ack;
    logic [15:0] mem_data;

    modport master (
        output mem_rd,
        output mem_addr,
        input  mem_busy,
        input  mem_ack,
        input  mem_data
    );

    modport slave (
        input  mem_rd,
        input  mem_addr,
        output mem_busy,
        output mem_ack,
        output mem_data
    );
endinterface

// File: rtl/groovy_audio_stream.sv
// Audio playback stage: fetches PCM words from the DDR ring into a FIFO and plays them at a
// fractional tick rate. Optional underrun counter built when GROOVY_AUDIO_UNDERRUN_CNT_EN is defined.
module groovy_audio_stream #(
    parameter int unsigned CLK_HZ    = 48000000,
    parameter int unsigned FIFO_AW   = 10,
    parameter logic [23:0] AUD_BASE  = 24'h000000,
    parameter logic [23:0] AUD_WORDS = 24'h010000
) (
    input  logic                         clk_sys,
    input  logic                         reset_n,
    input  logic                         cmd_audio,
    input  logic [15:0]                  audio_samples,
    output logic                         reset_audio,
    input  logic [1:0]                   sound_rate,
    input  logic [1:0]                   sound_chan,
    groovy_audio_stream_if.master        mem,
    output logic [15:0]                  audio_l,
    output logic [15:0]                  audio_r,
    output logic                         sample_strobe,
    output logic                         audio_busy,
    output logic [15:0]                  underrun_cnt
);

    localparam int unsigned Depth = 1 << FIFO_AW;
    localparam int unsigned PW    = FIFO_AW + 1;
    localparam logic [FIFO_AW:0] FifoFull = {1'b1, {FIFO_AW{1'b0}}};

    typedef enum logic [0:0] {StIdle, StWait} state_e;

    state_e             state_q, state_d;
    logic               abort_q, abort_d;
    logic [23:0]        rd_ptr_q, rd_ptr_d;
    logic [16:0]        remaining_q, remaining_d;
    logic [FIFO_AW:0]   wr_q, wr_d, rd_q, rd_d;
    logic [31:0]        acc_q, acc_d;
    logic [1:0]         rate_q, chan_q;
    logic [15:0]        audio_l_q, audio_l_d, audio_r_q, audio_r_d;
    logic               strobe_q, strobe_d;
    logic               reset_audio_q, reset_audio_d;

    logic [15:0]        fifo_mem [Depth];

    logic               mode_chg, cmd_take, issue, push, tick, tick_en, have_data, stereo;
    logic [1:0]         pop_n;
    logic [FIFO_AW:0]   count;
    logic [FIFO_AW-1:0] rd_idx, rd_idx1;
    logic [31:0]        rate_inc, acc_sum;
    logic [16:0]        rem_base;
    logic [17:0]        rem_sum;

    assign mode_chg = (sound_rate != rate_q) || (sound_chan != chan_q);
    assign cmd_take = cmd_audio && !reset_audio_q;
    assign count    = wr_q - rd_q;
    assign rd_idx   = rd_q[FIFO_AW-1:0];
    assign rd_idx1  = rd_idx + FIFO_AW'(1);
    assign stereo   = chan_q[1];
    assign tick_en  = (rate_q != 2'd0) && (chan_q != 2'd0);

    // Reads wait out the ack of an aborted request so a stale word is never mistaken for a new one.
    assign issue = (state_q == StIdle) && !abort_q && (remaining_q != 17'd0) &&
                   (count != FifoFull) && !mem.mem_busy && !mode_chg;
    assign push  = (state_q == StWait) && mem.mem_ack && !mode_chg;

    always_comb begin
        unique case (rate_q)
            2'd1:    rate_inc = 32'd22050;
            2'd2:    rate_inc = 32'd44100;
            2'd3:    rate_inc = 32'd48000;
            default: rate_inc = 32'd0;
        endcase
    end

    assign acc_sum = acc_q + rate_inc;
    assign tick    = tick_en && !mode_chg && (acc_sum >= CLK_HZ);

    always_comb begin
        state_d       = state_q;
        abort_d       = abort_q;
        rd_ptr_d      = rd_ptr_q;
        wr_d          = wr_q;
        rd_d          = rd_q;
        acc_d         = acc_q;
        audio_l_d     = audio_l_q;
        audio_r_d     = audio_r_q;
        strobe_d      = tick;
        reset_audio_d = cmd_take;
        pop_n         = 2'd0;
        have_data     = 1'b0;
        rem_base      = remaining_q;
        rem_sum       = 18'd0;
        remaining_d   = remaining_q;

        // Fetch FSM
        unique case (state_q)
            StIdle: if (issue) state_d = StWait;
            StWait: if (mem.mem_ack) state_d = StIdle;
            default: state_d = StIdle;
        endcase

        if (abort_q && mem.mem_ack) abort_d = 1'b0;

        if (push) begin
            rd_ptr_d = (rd_ptr_q == AUD_WORDS - 24'd1) ? 24'd0 : rd_ptr_q + 24'd1;
            rem_base = remaining_q - 17'd1;
        end

        // Playback
        if (tick_en && !mode_chg) acc_d = tick ? acc_sum - CLK_HZ : acc_sum;
        if (tick) begin
            if (stereo) begin
                have_data = count >= PW'(2);
                if (have_data) begin
                    pop_n     = 2'd2;
                    audio_l_d = fifo_mem[rd_idx];
                    audio_r_d = fifo_mem[rd_idx1];
                end
            end else begin
                have_data = count != '0;
                if (have_data) begin
                    pop_n     = 2'd1;
                    audio_l_d = fifo_mem[rd_idx];
                    audio_r_d = fifo_mem[rd_idx];
                end
            end
        end

        wr_d = wr_q + PW'(push);
        rd_d = rd_q + PW'(pop_n);

        if (mode_chg) begin
            state_d   = StIdle;
            abort_d   = (state_q == StWait) && !mem.mem_ack;
            rd_ptr_d  = 24'd0;
            rem_base  = 17'd0;
            wr_d      = '0;
            rd_d      = '0;
            acc_d     = 32'd0;
            audio_l_d = 16'd0;
            audio_r_d = 16'd0;
        end

        // A command in a mode-change cycle lands on the already-cleared count.
        remaining_d = rem_base;
        if (cmd_take) begin
            rem_sum     = {1'b0, rem_base} + {2'b00, audio_samples};
            remaining_d = rem_sum[17] ? 17'h1FFFF : rem_sum[16:0];
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= StIdle;
            abort_q       <= 1'b0;
            rd_ptr_q      <= 24'd0;
            remaining_q   <= 17'd0;
            wr_q          <= '0;
            rd_q          <= '0;
            acc_q         <= 32'd0;
            rate_q        <= 2'd0;
            chan_q        <= 2'd0;
            audio_l_q     <= 16'd0;
            audio_r_q     <= 16'd0;
            strobe_q      <= 1'b0;
            reset_audio_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            abort_q       <= abort_d;
            rd_ptr_q      <= rd_ptr_d;
            remaining_q   <= remaining_d;
            wr_q          <= wr_d;
            rd_q          <= rd_d;
            acc_q         <= acc_d;
            rate_q        <= sound_rate;
            chan_q        <= sound_chan;
            audio_l_q     <= audio_l_d;
            audio_r_q     <= audio_r_d;
            strobe_q      <= strobe_d;
            reset_audio_q <= reset_audio_d;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (push) fifo_mem[wr_q[FIFO_AW-1:0]] <= mem.mem_data;
    end

`ifdef GROOVY_AUDIO_UNDERRUN_CNT_EN
    logic [15:0] under_q, under_d;
    logic        underrun;

    assign underrun = tick && !have_data;

    always_comb begin
        under_d = under_q;
        if (mode_chg) under_d = 16'd0;
        else if (underrun && under_q != 16'hFFFF) under_d = under_q + 16'd1;
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) under_q <= 16'd0;
        else          under_q <= under_d;
    end

    assign underrun_cnt = under_q;
`else
    assign underrun_cnt = 16'd0;
`endif

    assign mem.mem_rd   = issue;
    assign mem.mem_addr = AUD_BASE + rd_ptr_q;
    assign reset_audio  = reset_audio_q;
    assign audio_l      = audio_l_q;
    assign audio_r      = audio_r_q;
    assign sample_strobe = strobe_q;
    assign audio_busy   = (remaining_q != 17'd0) || (state_q == StWait) || (count != '0);

endmodule

// File: tb/tb_groovy_audio_stream.sv
// Scoreboard bench for groovy_audio_stream: a small ring-buffer memory model answers reads and a
// negedge monitor checks every sample_strobe against the queued expectations.
module tb_groovy_audio_stream;

    localparam int unsigned ClkHz    = 48000000;
    localparam int unsigned FifoAw   = 2;
    localparam logic [23:0] AudBase  = 24'h000100;
    localparam logic [23:0] AudWords = 24'd8;
`ifdef GROOVY_AUDIO_UNDERRUN_CNT_EN
    localparam int UnderOne = 1;
`else
    localparam int UnderOne = 0;
`endif

    logic        clk_sys = 1'b0;
    logic        reset_n = 1'b0;
    logic        cmd_audio = 1'b0;
    logic [15:0] audio_samples = 16'd0;
    logic [1:0]  sound_rate = 2'd0;
    logic [1:0]  sound_chan = 2'd0;
    logic        reset_audio, sample_strobe, audio_busy;
    logic [15:0] audio_l, audio_r, underrun_cnt;

    groovy_audio_stream_if bus ();

    groovy_audio_stream #(
        .CLK_HZ   (ClkHz),
        .FIFO_AW  (FifoAw),
        .AUD_BASE (AudBase),
        .AUD_WORDS(AudWords)
    ) dut (
        .clk_sys      (clk_sys),
        .reset_n      (reset_n),
        .cmd_audio    (cmd_audio),
        .audio_samples(audio_samples),
        .reset_audio  (reset_audio),
        .sound_rate   (sound_rate),
        .sound_chan   (sound_chan),
        .mem          (bus),
        .audio_l      (audio_l),
        .audio_r      (audio_r),
        .sample_strobe(sample_strobe),
        .audio_busy   (audio_busy),
        .underrun_cnt (underrun_cnt)
    );

    always #5 clk_sys = ~clk_sys;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Memory model
    logic [15:0] img [8];
    logic [15:0] pend = 16'd0;
    int          mem_lat = 2;
    int          lat_cnt = 0;
    int          rd_count = 0;
    logic [23:0] addr_log [$];

    always @(posedge clk_sys) begin
        bus.mem_ack <= 1'b0;
        if (lat_cnt > 0) begin
            lat_cnt <= lat_cnt - 1;
            if (lat_cnt == 1) begin
                bus.mem_ack  <= 1'b1;
                bus.mem_data <= pend;
            end
        end
        if (bus.mem_rd === 1'b1) begin
            addr_log.push_back(bus.mem_addr);
            rd_count <= rd_count + 1;
            pend     <= img[3'(bus.mem_addr - AudBase)];
            lat_cnt  <= mem_lat;
        end
    end

    // Scoreboard and monitor
    logic [31:0] sb_q [$];
    logic [31:0] sb_e;
    logic [15:0] exp_l = 16'd0;
    logic [15:0] exp_r = 16'd0;
    int          exp_under = 0;
    int          strobe_seen = 0;
    int          cyc = 0;
    int          strobe_cyc [$];

    always @(posedge clk_sys) cyc <= cyc + 1;

    initial forever begin
        @(negedge clk_sys);
        if (reset_n && sample_strobe) begin
            strobe_seen++;
            strobe_cyc.push_back(cyc);
            if (sb_q.size() > 0) begin
                sb_e  = sb_q.pop_front();
                exp_l = sb_e[31:16];
                exp_r = sb_e[15:0];
            end else if (exp_under < 65535) begin
                exp_under = exp_under + UnderOne;
            end
            check("strobe audio_l", audio_l, exp_l);
            check("strobe audio_r", audio_r, exp_r);
            check("strobe underrun_cnt", underrun_cnt, exp_under);
        end
    end

    task automatic step(input int n = 1);
        repeat (n) @(posedge clk_sys);
        #1;
    endtask

    task automatic wait_strobes(input int target, input int budget, input string name);
        int k = 0;
        while (strobe_seen < target && k < budget) begin
            step();
            k++;
        end
        check(name, strobe_seen >= target, 1);
    endtask

    task automatic send_cmd(input logic [15:0] n);
        audio_samples = n;
        cmd_audio     = 1'b1;
        step();
        check("reset_audio ack", reset_audio, 1);
        cmd_audio = 1'b0;
        step();
        check("reset_audio single", reset_audio, 0);
    endtask

    task automatic set_mode(input logic [1:0] rate, input logic [1:0] chan);
        sound_rate = rate;
        sound_chan = chan;
        step();
        exp_l     = 16'd0;
        exp_r     = 16'd0;
        exp_under = 0;
    endtask

    int base;
    int hi;
    int k;

    initial begin
        img = '{16'h0001, 16'h0002, 16'h0003, 16'h0004, 16'h7FFF, 16'h8000, 16'hFFFE, 16'h1234};
        bus.mem_busy = 1'b0;
        step(3);
        check("rst reset_audio", reset_audio, 0);
        check("rst mem_rd", bus.mem_rd, 0);
        check("rst mem_addr", bus.mem_addr, AudBase);
        check("rst audio_l", audio_l, 0);
        check("rst audio_r", audio_r, 0);
        check("rst sample_strobe", sample_strobe, 0);
        check("rst audio_busy", audio_busy, 0);
        check("rst underrun_cnt", underrun_cnt, 0);
        reset_n = 1'b1;
        step(2);

        // Stereo 48 kHz, four words
        set_mode(2'd3, 2'd2);
        step(4);
        sb_q.push_back({16'h0001, 16'h0002});
        sb_q.push_back({16'h0003, 16'h0004});
        strobe_cyc.delete();
        send_cmd(16'd4);
        step(40);
        check("busy while buffered", audio_busy, 1);
        wait_strobes(strobe_seen + 2, 2500, "two stereo strobes");
        if (strobe_cyc.size() >= 2) check("48k tick spacing", strobe_cyc[1] - strobe_cyc[0], 1000);
        step();
        check("busy after drain", audio_busy, 0);

        // Ring wrap: rd_ptr now 4
        addr_log.delete();
        sb_q.push_back({16'h7FFF, 16'h8000});
        send_cmd(16'd2);
        wait_strobes(strobe_seen + 1, 1100, "wrap strobe 1");
        sb_q.push_back({16'hFFFE, 16'h1234});
        sb_q.push_back({16'h0001, 16'h0002});
        send_cmd(16'd4);
        wait_strobes(strobe_seen + 2, 2200, "wrap strobes 2-3");
        check("wrap read count", addr_log.size(), 6);
        for (int i = 0; i < 6 && i < addr_log.size(); i++)
            check($sformatf("wrap addr %0d", i), addr_log[i], AudBase + 24'((4 + i) % 8));

        // FIFO back-pressure and accumulating command; rd_ptr now 2
        addr_log.delete();
        base = rd_count;
        for (int i = 0; i < 2; i++) begin
            sb_q.push_back({16'h0003, 16'h0004});
            sb_q.push_back({16'h7FFF, 16'h8000});
            sb_q.push_back({16'hFFFE, 16'h1234});
            sb_q.push_back({16'h0001, 16'h0002});
        end
        send_cmd(16'd10);
        step(60);
        check("reads when FIFO full", rd_count - base, 4);
        check("remaining after fill", dut.remaining_q, 6);
        hi = 0;
        repeat (20) begin
            if (bus.mem_rd) hi++;
            step();
        end
        check("mem_rd held low", hi, 0);
        audio_samples = 16'd6;
        cmd_audio     = 1'b1;
        step();
        check("accum ack", reset_audio, 1);
        step();
        check("accum ignored in ack cycle", reset_audio, 0);
        cmd_audio = 1'b0;
        step();
        check("accum no second ack", reset_audio, 0);
        check("remaining accumulated", dut.remaining_q, 12);
        wait_strobes(strobe_seen + 8, 8500, "accum strobes");
        check("accum read count", addr_log.size(), 16);
        for (int i = 0; i < 16 && i < addr_log.size(); i++)
            check($sformatf("accum addr %0d", i), addr_log[i], AudBase + 24'((2 + i) % 8));
        check("busy after accum drain", audio_busy, 0);

        // Mono 22050 with command in the mode-change cycle
        sound_rate    = 2'd1;
        sound_chan    = 2'd1;
        audio_samples = 16'd3;
        cmd_audio     = 1'b1;
        step();
        exp_l     = 16'd0;
        exp_r     = 16'd0;
        exp_under = 0;
        cmd_audio = 1'b0;
        check("mode+cmd ack", reset_audio, 1);
        check("mode+cmd remaining", dut.remaining_q, 3);
        check("mode clears audio_l", audio_l, 0);
        sb_q.push_back({16'h0001, 16'h0001});
        sb_q.push_back({16'h0002, 16'h0002});
        sb_q.push_back({16'h0003, 16'h0003});
        wait_strobes(strobe_seen + 4, 8800, "mono strobes");
        check("mono underrun hold", audio_l, 16'h0003);
        check("mono underrun count", underrun_cnt, UnderOne);

        // Abort in WAIT; rd_ptr now 3
        mem_lat = 40;
        base    = rd_count;
        send_cmd(16'd4);
        k = 0;
        while (rd_count - base < 4 && k < 400) begin
            step();
            k++;
        end
        check("abort fourth read issued", rd_count - base, 4);
        step(5);
        check("busy before abort", audio_busy, 1);
        set_mode(2'd1, 2'd2);
        check("abort audio_l", audio_l, 0);
        check("abort audio_r", audio_r, 0);
        check("abort busy", audio_busy, 0);
        step(50);
        check("stale ack dropped", audio_busy, 0);
        check("no read after abort", rd_count - base, 4);
        wait_strobes(strobe_seen + 1, 2300, "post-abort strobe");
        mem_lat = 2;

        step(5);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/groovy_audio_stream.md
# groovy_audio_stream

Audio playback stage directly downstream of the HPS command decoder. Accepts `SET_AUDIO` commands (`cmd_audio`/`audio_samples`), fetches that many 16-bit PCM words from the DDR audio ring buffer, buffers them in an on-chip FIFO, and emits L/R samples at the rate selected by `sound_rate`/`sound_chan`. It returns the `reset_audio` acknowledge and the `audio_busy` status bit reported in `GET_GROOVY_STATUS`.

## Interface
- `CLK_HZ`, 48000000: `clk_sys` frequency in Hz.
- `FIFO_AW`, 10: FIFO address width; depth is 2^FIFO_AW words.
- `AUD_BASE`, 24'h000000: word address of the ring buffer in DDR.
- `AUD_WORDS`, 24'h010000: ring size in 16-bit words; wrap point.
- `clk_sys` in 1: system clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `cmd_audio` in 1: level; a new audio block is pending.
- `audio_samples` in 16: words in the pending block.
- `reset_audio` out 1: one-cycle acknowledge of `cmd_audio`.
- `sound_rate` in 2: 0 = off, 1 = 22050 Hz, 2 = 44100 Hz, 3 = 48000 Hz.
- `sound_chan` in 2: 0 = off, 1 = mono, 2/3 = stereo (L then R in memory).
- `mem_rd` out 1: one-cycle read request.
- `mem_addr` out 24: word address, equal to `AUD_BASE` + `rd_ptr`.
- `mem_busy` in 1: memory cannot accept a request this cycle.
- `mem_ack` in 1: `mem_data` valid.
- `mem_data` in 16: returned word.
- `audio_l` out 16: left sample (signed).
- `audio_r` out 16: right sample (signed).
- `sample_strobe` out 1: one-cycle pulse when `audio_l`/`audio_r` update.
- `audio_busy` out 1: `remaining` ≠ 0, a read is outstanding, or the FIFO is non-empty.
- `underrun_cnt` out 16: count of sample ticks that found insufficient FIFO data (see Configuration).

## Operation
- Reset values: all outputs 0; `rd_ptr`, `remaining` (17 bits), FIFO pointers and tick accumulator cleared.
- **Command absorb:** if `cmd_audio`=1 and `reset_audio`=0 in cycle N:
  - `remaining` ← min(`remaining` + `audio_samples`, 2^17−1).
  - `reset_audio`=1 in N+1; `cmd_audio` is ignored in N+1.
  - A command arriving during active fetching accumulates into `remaining`; it does not restart the fetch.
- **Fetch FSM:**
  - `IDLE`: if `remaining`≠0 and the FIFO has ≥1 free slot, and `mem_busy`=0, pulse `mem_rd` and go to `WAIT`.
  - `WAIT`: on `mem_ack`, push `mem_data`, `remaining`−1, and `rd_ptr`+1; `rd_ptr` wraps to 0 at `AUD_WORDS`−1→0. Then return to `IDLE`.
  - At most one read is outstanding.
  - A free slot is checked before issue, so the FIFO never overflows.
- **Tick generator:**
  - `acc` (32 bits) += rate each cycle; when `acc` ≥ `CLK_HZ`, `acc` −= `CLK_HZ` and a tick fires.
  - No ticks are generated when `sound_rate`=0 or `sound_chan`=0.
- **Output on tick:**
  - Stereo: if FIFO count ≥2, pop L then R.
  - Mono: if count ≥1, pop one word to both `audio_l` and `audio_r`.
  - Insufficient data: outputs hold their previous value, nothing is popped, and the underrun event fires.
  - `sample_strobe` pulses on every tick, including underruns.
- **Mode change:** any change of `sound_rate` or `sound_chan` (compared against registered copies) flushes the FIFO, zeroes `remaining`, `rd_ptr`, `acc`, `audio_l` and `audio_r`, and aborts `WAIT`.
  - The `mem_ack` of an aborted read is discarded.
  - A `cmd_audio` in the same cycle as the change is acknowledged, and its `audio_samples` is loaded after the clear.
- **Simultaneous push and pop:** push and pop in the same cycle are legal; the count is unchanged net of both.

## Timing
- `cmd_audio` rise → `reset_audio` pulse: 1 cycle.
- `mem_rd` is issued ≥1 cycle after `remaining` becomes non-zero.
- `mem_ack` → FIFO write is same-edge; the word is poppable next cycle.
- Tick → `audio_l`/`audio_r`/`sample_strobe` valid: 1 cycle, registered.
- At 48 MHz / 48000 Hz, a tick occurs every exactly 1000 cycles. At 44100 Hz, tick spacing is 1088 or 1089 cycles with zero long-term drift.
- Asynchronous `reset_n` mid-transaction drops `mem_rd` immediately. A stale `mem_ack` after reset is ignored because the FSM is in `IDLE`.

## Configuration
- `GROOVY_AUDIO_UNDERRUN_CNT_EN` defined:
  - `underrun_cnt` increments on each underrun tick and saturates at 16'hFFFF.
  - It clears on reset and on mode change.
- Not defined: `underrun_cnt` is constant 0 and no counter logic is built.

## Test plan
- Stereo 48 kHz, `audio_samples`=4, memory holds 0x0001..0x0004 → `reset_audio` 1 cycle after `cmd_audio`; two strobes 1000 cycles apart give (L,R)=(1,2) then (3,4); `audio_busy` falls after the second pop.
- Mono 22050, `audio_samples`=3 → `audio_l`=`audio_r` per tick; the 4th tick is an underrun with outputs holding 3 and `underrun_cnt`=1 (macro on) or 0 (macro off).
- `rd_ptr`=`AUD_WORDS`−2, 4 words → `mem_addr` = `AUD_BASE`+`AUD_WORDS`−2, `AUD_BASE`+`AUD_WORDS`−1, `AUD_BASE`, `AUD_BASE`+1.
- `FIFO_AW`=2, `audio_samples`=10, no ticks → exactly 4 reads issued, `remaining`=6; `mem_rd` stays low until a pop.
- Second `cmd_audio`(5) while 3 words remain → `remaining`=8, single ack per command, no address restart.
- Change `sound_chan` 2→1 while in `WAIT` with FIFO=6 → FIFO empty, outputs 0; the late `mem_ack` is not pushed; `audio_busy`=0 next cycle.
